// File: rtl/pc_gen_stage_if.sv
// Fetch-stage bundle: the pipeline's redirect requests and stall, plus the
// instruction SRAM fetch request and status flags driven by pc_gen_stage.
interface pc_gen_stage_if;
    logic        stall;
    logic        exception;
    logic        eret;
    logic [31:0] epc;
    logic        br_taken;
    logic [31:0] br_target;
    logic        inst_sram_en;
    logic [31:0] inst_sram_raddr;
    logic        fetch_adel;
    logic        pend_valid;

    modport master (
        output stall, exception, eret, epc, br_taken, br_target,
        input  inst_sram_en, inst_sram_raddr, fetch_adel, pend_valid
    );

    modport slave (
        input  stall, exception, eret, epc, br_taken, br_target,
        output inst_sram_en, inst_sram_raddr, fetch_adel, pend_valid
    );
endinterface

// File: rtl/pc_gen_stage.sv
// PC generation with ranked redirects (exception > eret > branch > sequential)
// and a one-entry pending buffer while stalled. FETCH_ADDR_ALIGN_CHECK_EN enables fetch_adel.
module pc_gen_stage #(
    parameter logic [31:0] RESET_PC   = 32'hbfc00000,
    parameter logic [31:0] EXC_VECTOR = 32'hbfc00380
) (
    input  logic          clk,
    input  logic          resetn,
    pc_gen_stage_if.slave bus
);
    typedef enum logic {RUN, PEND} state_t;

    state_t      state_reg;
    logic [31:0] pc_reg;
    logic        en_reg;
    logic [1:0]  pend_rank_reg;
    logic [31:0] pend_target_reg;

    logic [1:0]  cur_rank;
    logic [31:0] cur_target;
    logic        cur_req;
    logic        cur_wins;

    // Only the highest-ranked request of a cycle survives.
    always_comb begin
        cur_rank   = 2'd0;
        cur_target = 32'h0;
        if (bus.exception) begin
            cur_rank   = 2'd3;
            cur_target = EXC_VECTOR;
        end else if (bus.eret) begin
            cur_rank   = 2'd2;
            cur_target = bus.epc;
        end else if (bus.br_taken) begin
            cur_rank   = 2'd1;
            cur_target = bus.br_target;
        end
    end

    assign cur_req  = (cur_rank != 2'd0);
    assign cur_wins = cur_req && (cur_rank >= pend_rank_reg);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pc_reg          <= RESET_PC;
            en_reg          <= 1'b0;
            state_reg       <= RUN;
            pend_rank_reg   <= 2'd0;
            pend_target_reg <= 32'h0;
        end else if (!en_reg) begin
            // First edge out of reset only enables fetch; PC stays at RESET_PC.
            en_reg <= 1'b1;
        end else begin
            case (state_reg)
                RUN: begin
                    if (!bus.stall) begin
                        pc_reg <= cur_req ? cur_target : pc_reg + 32'd4;
                    end else if (cur_req) begin
                        pend_rank_reg   <= cur_rank;
                        pend_target_reg <= cur_target;
                        state_reg       <= PEND;
                    end
                end
                PEND: begin
                    if (bus.stall) begin
                        if (cur_wins) begin
                            pend_rank_reg   <= cur_rank;
                            pend_target_reg <= cur_target;
                        end
                    end else begin
                        pc_reg          <= cur_wins ? cur_target : pend_target_reg;
                        pend_rank_reg   <= 2'd0;
                        pend_target_reg <= 32'h0;
                        state_reg       <= RUN;
                    end
                end
                default: state_reg <= RUN;
            endcase
        end
    end

    assign bus.inst_sram_en    = en_reg;
    assign bus.inst_sram_raddr = pc_reg;
    assign bus.pend_valid      = (state_reg == PEND);

`ifdef FETCH_ADDR_ALIGN_CHECK_EN
    assign bus.fetch_adel = en_reg && (pc_reg[1:0] != 2'b00);
`else
    assign bus.fetch_adel = 1'b0;
`endif
endmodule
